// File: rtl/axis_eth_frame_checker.sv
// Ethernet RX frame checker: counts bytes per frame, marks runt/oversize/upstream-bad
// frames on the tlast beat and truncates oversize frames, with one registered output stage.
module axis_eth_frame_checker #(
    parameter int   DATA_WIDTH           = 8,
    parameter int   KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int   MIN_LEN              = 64,
    parameter int   MAX_LEN              = 1518,
    parameter int   LEN_WIDTH            = 16,
    parameter logic USER_BAD_FRAME_VALUE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  status_runt,
    output logic                  status_oversize,
    output logic [LEN_WIDTH-1:0]  status_frame_len
);

    typedef enum logic [0:0] {
        ST_PASS    = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
    localparam logic                 BAD   = USER_BAD_FRAME_VALUE;

    state_t               state;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] beat_bytes;
    logic [LEN_WIDTH-1:0] next_len;
    logic                 tuser_acc;
    logic                 accept;
    logic                 frame_bad;

    // Tail of a truncated frame is swallowed without backpressure.
    assign s_axis_tready = (state == ST_DISCARD) || !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign next_len      = len + beat_bytes;
    assign frame_bad     = tuser_acc || s_axis_tuser || (next_len < MIN_L);

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + LEN_WIDTH'(s_axis_tkeep[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_PASS;
            len              <= '0;
            tuser_acc        <= 1'b0;
            m_axis_tdata     <= '0;
            m_axis_tkeep     <= '0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tlast     <= 1'b0;
            m_axis_tuser     <= 1'b0;
            status_runt      <= 1'b0;
            status_oversize  <= 1'b0;
            status_frame_len <= '0;
        end else begin
            status_runt     <= 1'b0;
            status_oversize <= 1'b0;
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    ST_PASS: begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tkeep  <= s_axis_tkeep;
                        m_axis_tvalid <= 1'b1;
                        if (next_len > MAX_L) begin
                            m_axis_tlast     <= 1'b1;
                            m_axis_tuser     <= BAD;
                            status_oversize  <= 1'b1;
                            status_frame_len <= next_len;
                            len              <= '0;
                            tuser_acc        <= 1'b0;
                            if (!s_axis_tlast) begin
                                state <= ST_DISCARD;
                            end
                        end else if (s_axis_tlast) begin
                            m_axis_tlast     <= 1'b1;
                            m_axis_tuser     <= frame_bad ? BAD : ~BAD;
                            status_runt      <= (next_len < MIN_L);
                            status_frame_len <= next_len;
                            len              <= '0;
                            tuser_acc        <= 1'b0;
                        end else begin
                            m_axis_tlast <= 1'b0;
                            m_axis_tuser <= ~BAD;
                            len          <= next_len;
                            tuser_acc    <= tuser_acc | s_axis_tuser;
                        end
                    end
                    ST_DISCARD: begin
                        if (s_axis_tlast) begin
                            state <= ST_PASS;
                        end
                    end
                    default: state <= ST_PASS;
                endcase
            end
        end
    end

endmodule

// File: doc/axis_eth_frame_checker.md
Name: axis_eth_frame_checker

Overview:
- AXI4-Stream Ethernet RX frame checker, directly upstream of the RX frame FIFO (frame mode, DROP_BAD_FRAME=1).
- Counts bytes per frame, flags runt and oversize frames, and truncates oversize frames.
- Marks failing frames with tuser = USER_BAD_FRAME_VALUE on the tlast beat so the FIFO drops them.
- Single registered output stage; 1-cycle latency.

Parameters:
- DATA_WIDTH, 8, stream data width in bits (multiple of 8).
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- MIN_LEN, 64, minimum legal frame length in bytes (inclusive).
- MAX_LEN, 1518, maximum legal frame length in bytes (inclusive).
- LEN_WIDTH, 16, byte counter width; must satisfy 2^LEN_WIDTH > MAX_LEN + KEEP_WIDTH.
- USER_BAD_FRAME_VALUE, 1'b1, tuser value that marks a bad frame.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables; contiguous from LSB.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of frame.
- s_axis_tuser  in  1  upstream bad-frame marker (e.g. MAC FCS error).
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tuser  out  1  output bad-frame marker.
- status_runt  out  1  one-cycle pulse: runt frame ended.
- status_oversize  out  1  one-cycle pulse: oversize frame truncated.
- status_frame_len  out  LEN_WIDTH  byte length of the last completed frame.

Behaviour:
- Reset (asynchronous, active-low): immediately clears m_axis_tvalid, m_axis_tlast, m_axis_tuser, status_runt, status_oversize, status_frame_len, byte counter; state=PASS.
  - Data/keep output registers reset to 0.
  - A reset mid-frame discards the partial frame; no tlast is emitted.
- Handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready in PASS; constant 1 in DISCARD.
  - Beat accepted when s_axis_tvalid && s_axis_tready.
  - m_axis_* hold stable while m_axis_tvalid && !m_axis_tready.
- Latency: an accepted PASS beat appears on m_axis the next cycle. Full throughput of 1 beat/cycle under continuous tready.
- Byte count:
  - beat_bytes = popcount(s_axis_tkeep).
  - next_len = len + beat_bytes.
  - Counter clears after each frame end (natural or truncated).
- State PASS, per accepted beat:
  - tuser_acc |= s_axis_tuser.
  - If next_len > MAX_LEN: forward the beat with m_tlast=1, m_tuser=BAD, pulse status_oversize, status_frame_len=next_len.
    - If s_axis_tlast=0 -> go to DISCARD; else stay in PASS.
  - Else if s_axis_tlast: forward with m_tlast=1, status_frame_len=next_len.
    - m_tuser = BAD if (tuser_acc || s_axis_tuser || next_len < MIN_LEN), else !BAD.
    - Pulse status_runt if next_len < MIN_LEN.
  - Else: forward with m_tlast=0, m_tuser=!BAD.
- State DISCARD: accept and drop every beat; no output; no status. On accepted tlast -> PASS, counter and tuser_acc cleared.
- Status pulses assert in the cycle after the frame-ending beat is accepted. status_frame_len holds until the next frame end.
- Boundaries:
  - next_len == MAX_LEN is legal; next_len == MIN_LEN is legal.
  - A single-beat frame with tlast is handled in one beat.
  - tkeep=0 beats add 0 bytes and are still forwarded.
  - Simultaneous m_axis_tready and a new input beat replace the output register in the same cycle.

Test Plan:
- DATA_WIDTH=8: 64-byte frame, tuser=0, continuous ready -> 64 output beats, last tlast=1 tuser=0, status_frame_len=64, no pulses.
- 63-byte frame -> 63 beats, last tuser=1, status_runt pulses once, status_frame_len=63.
- 1600-byte frame -> 1519 output beats, beat 1519 has tlast=1 tuser=1; status_oversize pulses; remaining 81 beats accepted with tready=1 and not output. The next 100-byte frame passes clean.
- 1518-byte frame -> passes with tuser=0. 100-byte frame with s_axis_tuser=1 on beat 10 only -> final beat tuser=1.
- Random m_axis_tready (50%) over 10 back-to-back frames -> output byte sequence identical to input, no beat lost or duplicated, outputs stable while stalled.
- rst_n low mid-frame (beat 30 of 64) -> m_axis_tvalid=0 immediately. After release, a 64-byte frame outputs with status_frame_len=64.
